// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory load/store controller.
//   - request size codes, memory read/write strobe values
//   - FSM state enum and the latched request payload
//   - misalignment helper used at request accept
package dmem_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } state_e;

   // Only the fields needed after accept; the word address goes straight to mem_addr.
   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [1:0]  lane;
      logic [15:0] wdata;
   } req_t;

   // Size code 3 is illegal and reported the same way as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// dmem_lsu_ctrl_if: request/response handshake plus the dMemBase memory port.
//   slave  : the load/store controller (accepts requests, drives memory)
//   master : the core + memory side (issues requests, returns mem_dataOut)
interface dmem_lsu_ctrl_if;
   import dmem_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [1:0]      req_size;
   logic            req_signed;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;

   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;

   logic [XLEN-1:0] mem_addr;
   logic            mem_enable;
   logic            mem_readwrite;
   logic [XLEN-1:0] mem_dataIn;
   logic [XLEN-1:0] mem_dataOut;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mem_addr, mem_enable, mem_readwrite, mem_dataIn
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mem_addr, mem_enable, mem_readwrite, mem_dataIn
   );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering.
//   word_i          word read from memory
//   wdata_i         right-justified sub-word store data
//   size_i, lane_i  access size and byte address bits [1:0]
//   sgn_i           sign-extend loads
//   store_word_c_o  word_i with the addressed lane(s) replaced by wdata_i
//   load_data_c_o   addressed lane shifted to bit 0 and extended
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [15:0]     wdata_i,
   input  logic [1:0]      size_i,
   input  logic [1:0]      lane_i,
   input  logic            sgn_i,
   output logic [XLEN-1:0] store_word_c_o,
   output logic [XLEN-1:0] load_data_c_o
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] mask;
   logic [XLEN-1:0] ins;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;

   // Store merge: mask out the target lane(s) and insert the new data.
   always_comb begin
      shamt = {lane_i, 3'b000};
      mask  = '0;
      ins   = '0;
      case (size_i)
         SZ_BYTE: begin
            mask = XLEN'(32'h0000_00ff) << shamt;
            ins  = XLEN'(wdata_i[7:0]) << shamt;
         end
         SZ_HALF: begin
            shamt = {lane_i[1], 4'b0000};
            mask  = XLEN'(32'h0000_ffff) << shamt;
            ins   = XLEN'(wdata_i) << shamt;
         end
         default: ;
      endcase
      store_word_c_o = (word_i & ~mask) | (ins & mask);
   end

   // Load extract: bring the lane to bit 0, then sign- or zero-extend.
   always_comb begin
      lane_b = 8'(word_i >> {lane_i, 3'b000});
      lane_h = lane_i[1] ? word_i[31:16] : word_i[15:0];
      case (size_i)
         SZ_BYTE: load_data_c_o = {{24{sgn_i & lane_b[7]}}, lane_b};
         SZ_HALF: load_data_c_o = {{16{sgn_i & lane_h[15]}}, lane_h};
         default: load_data_c_o = word_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: single-outstanding load/store initiator for the dMemBase port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : request/response handshake and memory port (slave view)
//   RD_LAT     : cycles from the read-enable cycle until mem_dataOut is valid
// Sub-word stores are read-modify-write since the memory has no byte enables.
// All outputs come straight from flops.
module dmem_lsu_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   dmem_lsu_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t            req_q, req_d;
   logic            ready_q, ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_rw_q, mem_rw_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_din_q, mem_din_d;

   logic [XLEN-1:0] store_word;
   logic [XLEN-1:0] load_data;

   dmem_lane_align u_align (
      .word_i         (bus.mem_dataOut),
      .wdata_i        (req_q.wdata),
      .size_i         (req_q.size),
      .lane_i         (req_q.lane),
      .sgn_i          (req_q.sgn),
      .store_word_c_o (store_word),
      .load_data_c_o  (load_data)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= MEM_READ;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
      end
   end

   // Next state; registered outputs are decoded from the state being entered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = '0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && ready_q) begin
               req_d.write = bus.req_write;
               req_d.size  = bus.req_size;
               req_d.sgn   = bus.req_signed;
               req_d.lane  = bus.req_addr[1:0];
               req_d.wdata = bus.req_wdata[15:0];
               mem_addr_d  = {bus.req_addr[XLEN-1:2], 2'b00};
               if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                  state_d   = ST_WRITE;
                  mem_din_d = bus.req_wdata;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
         end
         ST_WAIT: begin
            // mem_dataOut is valid in the last WAIT cycle and is consumed on its closing edge.
            if (cnt_q == '0) begin
               if (req_q.write) begin
                  state_d   = ST_WRITE;
                  mem_din_d = store_word;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = load_data;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WRITE: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ready_d  = (state_d == ST_IDLE);
      mem_en_d = (state_d == ST_READ) || (state_d == ST_WRITE);
      mem_rw_d = (state_d == ST_WRITE) ? MEM_WRITE : MEM_READ;
   end

   assign bus.req_ready     = ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.mem_enable    = mem_en_q;
   assign bus.mem_readwrite = mem_rw_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_dataIn    = mem_din_q;

endmodule
